// File: rtl/lzc_pipe.sv
// Pipelined leading/trailing-zero counter with valid/ready handshake and bubble collapsing.
// Define LZC_PIPE_NORM_EN to add the normalised-operand output out_norm.
module lzc_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_trail,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(WIDTH):0] out_count,
  output logic                   out_zero,
`ifdef LZC_PIPE_NORM_EN
  output logic [WIDTH-1:0]       out_norm,
`endif
  output logic [TAG_W-1:0]       out_tag
);

  localparam int LW = $clog2(WIDTH);
  localparam int W2 = 1 << LW;
  localparam int CW = LW + 1;

  // Register index k (1..STAGES) placed after tree level lvl, or 0 if none.
  function automatic int reg_of(input int lvl);
    int r;
    r = 0;
    for (int k = 1; k <= STAGES; k++)
      if ((k * LW + STAGES - 1) / STAGES == lvl) r = k;
    return r;
  endfunction

  logic [STAGES:1] sv;
  logic [STAGES:1] load;
  logic [STAGES:1] cap;
  logic [STAGES:0] vchain;

  assign vchain = {sv, in_valid};

  // A stage may load when it is empty or when everything below it can move.
  always_comb begin : p_load
    logic acc;
    acc  = out_ready;
    load = '0;
    cap  = '0;
    for (int k = STAGES; k >= 1; k--) begin
      acc     = acc | ~sv[k];
      load[k] = acc;
      cap[k]  = acc & vchain[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++)
        if (load[k]) sv[k] <= vchain[k-1];
    end
  end

  assign in_ready  = load[1];
  assign out_valid = vchain[STAGES];

  for (genvar l = 0; l <= LW; l++) begin : g_lvl
    localparam int RK = reg_of(l);
    logic [(W2>>l)-1:0]         cv, ov;
    logic [(W2>>l)-1:0][LW-1:0] cc, oc;
    logic [TAG_W-1:0]           ctag, otag;
`ifdef LZC_PIPE_NORM_EN
    logic [WIDTH-1:0]           cdata, odata;
    logic                       ctrail, otrail;
`endif

    if (l == 0) begin : g_leaf
      // Ones padded below the LSB stop the search at WIDTH for an all-zero operand.
      always_comb begin
        cv = '1;
        for (int i = 0; i < WIDTH; i++)
          cv[W2 - WIDTH + i] = in_trail ? in_data[WIDTH - 1 - i] : in_data[i];
        cc = '0;
      end
      assign ctag = in_tag;
`ifdef LZC_PIPE_NORM_EN
      assign cdata  = in_data;
      assign ctrail = in_trail;
`endif
    end else begin : g_merge
      always_comb begin
        cv = '0;
        cc = '0;
        for (int j = 0; j < (W2 >> l); j++) begin
          cv[j] = g_lvl[l-1].ov[2*j+1] | g_lvl[l-1].ov[2*j];
          cc[j] = g_lvl[l-1].ov[2*j+1] ? g_lvl[l-1].oc[2*j+1]
                                       : (g_lvl[l-1].oc[2*j] | LW'(1 << (l - 1)));
        end
      end
      assign ctag = g_lvl[l-1].otag;
`ifdef LZC_PIPE_NORM_EN
      assign cdata  = g_lvl[l-1].odata;
      assign ctrail = g_lvl[l-1].otrail;
`endif
    end

    if (RK != 0) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ov   <= '0;
          oc   <= '0;
          otag <= '0;
`ifdef LZC_PIPE_NORM_EN
          odata  <= '0;
          otrail <= 1'b0;
`endif
        end else if (cap[RK]) begin
          ov   <= cv;
          oc   <= cc;
          otag <= ctag;
`ifdef LZC_PIPE_NORM_EN
          odata  <= cdata;
          otrail <= ctrail;
`endif
        end
      end
    end else begin : g_thru
      assign ov   = cv;
      assign oc   = cc;
      assign otag = ctag;
`ifdef LZC_PIPE_NORM_EN
      assign odata  = cdata;
      assign otrail = ctrail;
`endif
    end
  end

  logic [CW-1:0] cnt;

  // Root block is only invalid for an all-zero operand when WIDTH is a power of two.
  always_comb begin
    cnt       = g_lvl[LW].ov[0] ? {1'b0, g_lvl[LW].oc[0]} : CW'(WIDTH);
    out_count = out_valid ? cnt : '0;
    out_zero  = out_valid & (cnt == CW'(WIDTH));
  end

  assign out_tag = g_lvl[LW].otag;

`ifdef LZC_PIPE_NORM_EN
  assign out_norm = g_lvl[LW].otrail ? (g_lvl[LW].odata >> cnt) : (g_lvl[LW].odata << cnt);
`endif

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed self-checking bench for lzc_pipe: a 32-bit/2-stage and a 20-bit/3-stage instance.
module tb_lzc_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, in_trail = 1'b0, out_valid, out_ready = 1'b1, out_zero;
  logic [31:0] in_data = '0;
  logic [3:0]  in_tag = '0, out_tag;
  logic [5:0]  out_count;
  logic [31:0] out_norm;

  logic        in_valid_20 = 1'b0, in_ready_20, in_trail_20 = 1'b0, out_valid_20, out_ready_20 = 1'b1, out_zero_20;
  logic [19:0] in_data_20 = '0;
  logic [3:0]  in_tag_20 = '0, out_tag_20;
  logic [5:0]  out_count_20;
  logic [19:0] out_norm_20;

  lzc_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_trail(in_trail), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_zero(out_zero),
`ifdef LZC_PIPE_NORM_EN
    .out_norm(out_norm),
`endif
    .out_tag(out_tag)
  );

  lzc_pipe #(.WIDTH(20), .STAGES(3), .TAG_W(4)) u_dut20 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_20), .in_ready(in_ready_20), .in_data(in_data_20), .in_trail(in_trail_20),
    .in_tag(in_tag_20),
    .out_valid(out_valid_20), .out_ready(out_ready_20), .out_count(out_count_20), .out_zero(out_zero_20),
`ifdef LZC_PIPE_NORM_EN
    .out_norm(out_norm_20),
`endif
    .out_tag(out_tag_20)
  );

`ifndef LZC_PIPE_NORM_EN
  assign out_norm    = '0;
  assign out_norm_20 = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input string nm, input logic [31:0] d, input logic tr, input logic [5:0] ec,
                       input logic ez, input logic [31:0] en, input logic [3:0] tg);
    int lat;
    in_data = d; in_trail = tr; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({nm, "_rdy"}, in_ready, 1);
    tick;
    in_valid = 1'b0; in_data = '1; in_trail = ~tr; in_tag = ~tg;
    lat = 1;
    while (!out_valid && lat < 10) begin tick; lat++; end
    chk({nm, "_lat"}, lat, 2);
    chk({nm, "_cnt"}, out_count, ec);
    chk({nm, "_zero"}, out_zero, ez);
    chk({nm, "_tag"}, out_tag, tg);
`ifdef LZC_PIPE_NORM_EN
    chk({nm, "_norm"}, out_norm, en);
`endif
    tick;
    chk({nm, "_drain"}, out_valid, 0);
  endtask

  task automatic run20(input string nm, input logic [19:0] d, input logic tr, input logic [5:0] ec,
                       input logic ez, input logic [19:0] en, input logic [3:0] tg);
    int lat;
    in_data_20 = d; in_trail_20 = tr; in_tag_20 = tg; in_valid_20 = 1'b1; out_ready_20 = 1'b1;
    #1 chk({nm, "_rdy"}, in_ready_20, 1);
    tick;
    in_valid_20 = 1'b0; in_data_20 = '1; in_trail_20 = ~tr; in_tag_20 = ~tg;
    lat = 1;
    while (!out_valid_20 && lat < 10) begin tick; lat++; end
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_cnt"}, out_count_20, ec);
    chk({nm, "_zero"}, out_zero_20, ez);
    chk({nm, "_tag"}, out_tag_20, tg);
`ifdef LZC_PIPE_NORM_EN
    chk({nm, "_norm"}, out_norm_20, en);
`endif
    tick;
    chk({nm, "_drain"}, out_valid_20, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_q[$];
    logic [3:0] exp_tag, tag_prev;
    logic [5:0] cnt_prev;
    logic       stall_prev, seen;
    int         sent, got, occ;

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_valid_20", out_valid_20, 0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("rst_ready", in_ready, 1);
    chk("rst_ready_20", in_ready_20, 1);

    run32("lead15",  32'h0001_0000, 1'b0, 6'd15, 1'b0, 32'h8000_0000, 4'h1);
    run32("zero_l",  32'h0000_0000, 1'b0, 6'd32, 1'b1, 32'h0000_0000, 4'h2);
    run32("trail8",  32'h0000_0100, 1'b1, 6'd8,  1'b0, 32'h0000_0001, 4'h3);
    run32("msb_l",   32'h8000_0000, 1'b0, 6'd0,  1'b0, 32'h8000_0000, 4'h4);
    run32("msb_t",   32'h8000_0000, 1'b1, 6'd31, 1'b0, 32'h0000_0001, 4'h5);
    run32("lsb_l",   32'h0000_0001, 1'b0, 6'd31, 1'b0, 32'h8000_0000, 4'h6);
    run32("ones_t",  32'hFFFF_FFFF, 1'b1, 6'd0,  1'b0, 32'hFFFF_FFFF, 4'h7);
    run32("zero_t",  32'h0000_0000, 1'b1, 6'd32, 1'b1, 32'h0000_0000, 4'h8);
    run32("lead17",  32'h0000_6000, 1'b0, 6'd17, 1'b0, 32'hC000_0000, 4'h9);

    run20("w20_lsb",   20'h00001, 1'b0, 6'd19, 1'b0, 20'h80000, 4'h1);
    run20("w20_msb",   20'h80000, 1'b0, 6'd0,  1'b0, 20'h80000, 4'h2);
    run20("w20_zero",  20'h00000, 1'b0, 6'd20, 1'b1, 20'h00000, 4'h3);
    run20("w20_trail", 20'h00010, 1'b1, 6'd4,  1'b0, 20'h00001, 4'h4);

    // Back-to-back stream of tags 0..7, downstream stalled for cycles 3..6.
    sent = 0; got = 0; occ = 0; stall_prev = 1'b0; tag_prev = '0; cnt_prev = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(posedge clk);
      #1;
      in_valid  = (sent < 8);
      in_tag    = sent[3:0];
      in_data   = 32'h1 << sent;
      in_trail  = 1'b0;
      out_ready = !(c >= 3 && c <= 6);
      #1;
      if (stall_prev) begin
        chk("bp_hold_v", out_valid, 1);
        chk("bp_hold_tag", out_tag, tag_prev);
        chk("bp_hold_cnt", out_count, cnt_prev);
      end
      chk("bp_ready", in_ready, ((occ < 2) || out_ready) ? 1 : 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(sent[3:0]);
        sent++;
        occ++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra", 1, 0);
        end else begin
          exp_tag = exp_q.pop_front();
          chk("bp_tag", out_tag, exp_tag);
          chk("bp_cnt", out_count, 6'd31 - {2'b00, exp_tag});
        end
        got++;
        occ--;
      end
      stall_prev = out_valid && !out_ready;
      tag_prev   = out_tag;
      cnt_prev   = out_count;
    end
    chk("bp_all", got, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    tick;

    // One result parked at the output; a second input still fills the empty stage.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0001_0000; in_trail = 1'b0; in_tag = 4'hA;
    #1 chk("bub_rdy_a", in_ready, 1);
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    chk("bub_hold_v", out_valid, 1);
    chk("bub_hold_tag", out_tag, 4'hA);
    in_valid = 1'b1; in_data = 32'h0000_0004; in_tag = 4'hB;
    #1 chk("bub_rdy_b", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("bub_first_tag", out_tag, 4'hA);
    chk("bub_first_cnt", out_count, 15);
    chk("bub_full", in_ready, 0);
    out_ready = 1'b1;
    tick;
    chk("bub_b_v", out_valid, 1);
    chk("bub_b_tag", out_tag, 4'hB);
    chk("bub_b_cnt", out_count, 29);
    tick;
    chk("bub_done", out_valid, 0);

    // Two transactions in flight, then an asynchronous reset between edges.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0010; in_tag = 4'h1;
    tick;
    in_tag = 4'h2;
    tick;
    in_valid = 1'b0;
    #1 chk("pre_rst_v", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_v", out_valid, 0);
    chk("async_rst_tag", out_tag, 0);
    chk("async_rst_cnt", out_count, 0);
    tick;
    #2 rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_stale", seen, 0);
    chk("rst_ready_after", in_ready, 1);

    run32("post_rst", 32'h0000_0400, 1'b0, 6'd21, 1'b0, 32'h8000_0000, 4'hC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzc_pipe.md
Name: lzc_pipe

Overview:
- Parametrised, pipelined leading/trailing-zero counter for normalisation paths (FP add/sub, int-to-float, priority encoders).
- Generalises the single-cycle power-of-two LZC tree:
  - any WIDTH ≥ 2;
  - selectable count direction per transaction;
  - configurable register depth;
  - valid/ready handshake with backpressure and bubble collapsing.

Parameters:
- WIDTH, 32: input data width, any value ≥ 2.
- STAGES, 2: pipeline register stages, 1..CW-1, where CW = $clog2(WIDTH)+1.
- TAG_W, 4: width of user tag carried alongside each transaction, ≥ 1.
- Derived, not overridable:
  - W2 = 2**$clog2(WIDTH);
  - CW = $clog2(WIDTH)+1 (count width; holds value WIDTH).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: input transaction valid.
- in_ready, out, 1: block can accept input this cycle.
- in_data, in, WIDTH: operand.
- in_trail, in, 1: 0 = count leading zeros from bit WIDTH-1; 1 = count trailing zeros from bit 0.
- in_tag, in, TAG_W: opaque user tag.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts result.
- out_count, out, CW: zero count.
- out_zero, out, 1: operand was all zeros.
- out_tag, out, TAG_W: tag of the result.

Behaviour:
- Reset: asynchronous, takes effect immediately, regardless of clock.
  - All stage valid bits clear; out_valid=0.
  - out_count=0, out_zero=0, out_tag=0.
  - in_ready=1 from the first cycle after reset deassert.
  - Transactions in flight at reset are discarded; no partial output.
- Operand conditioning, combinational in stage 0:
  - if in_trail=1, bit-reverse in_data;
  - extend to W2 bits by appending (W2-WIDTH) ones below the LSB, so padding never adds to the count.
- Count tree:
  - log2(W2) levels of pairwise merge, each producing (valid, partial count) per block;
  - the left child has priority when valid.
  - Pipeline registers are inserted after tree levels spread evenly: register k follows level ceil(k·log2(W2)/STAGES), k = 1..STAGES.
  - Last register feeds the outputs directly; no combinational path from in_* to out_*.
- Latency: an accepted transaction reaches out_valid exactly STAGES cycles later when out_ready has stayed 1.
- Throughput: 1 transaction/cycle.
- Results:
  - out_count = number of zeros before the first 1 in the selected direction, range 0..WIDTH-1 for nonzero input.
  - All-zero input: out_count = WIDTH (not W2), out_zero=1.
  - out_zero=0 for any nonzero input.
- Handshake:
  - Transfer on valid & ready at either side.
  - in_data, in_trail and in_tag are sampled only on input transfer.
  - out_valid, once raised, stays high with out_count, out_zero and out_tag stable until out_ready=1.
- Stall/bubble rule: stage k register loads when it is empty, or when its content advances in the same cycle.
  - Bubbles collapse: an empty stage fills even when downstream stages are stalled.
  - in_ready = !valid[1] | advance[1]. This is a combinational function of out_ready through the chain; an out_ready→in_ready path is accepted.
- Full pipeline with out_ready=0: in_ready=0, and no state changes.
- Simultaneous drain and fill: an output transfer and an input transfer in the same cycle are both honoured, with no lost or duplicated transaction.
- Order: results leave in acceptance order; tags are never reordered.

Optional Feature:
- Macro: LZC_PIPE_NORM_EN.
- Defined:
  - adds output port out_norm [WIDTH-1:0]. For in_trail=0 it equals in_data << count (MSB-justified); for in_trail=1 it equals in_data >> count (LSB-justified).
  - all-zero input gives out_norm=0; reset value 0.
  - The original operand travels down the pipe; the shift is done in the final stage.
  - Latency and handshake are unchanged.
- Undefined: port absent, no operand registers; the other ports behave identically.

Test Plan (WIDTH=32, STAGES=2 unless noted):
- Leading count: in_data=0x0001_0000, trail=0, out_ready=1 → 2 cycles later out_count=15, out_zero=0; with NORM_EN, out_norm=0x8000_0000.
- Zero and trailing: in_data=0, trail=0 → out_count=32, out_zero=1; in_data=0x0000_0100, trail=1 → out_count=8.
- Non-power-of-two width (WIDTH=20, STAGES=3):
  - 0x00001 → count 19;
  - 0x80000 → count 0;
  - 0 → count 20, zero=1;
  - latency 3.
- Backpressure: stream tags 0..7 back-to-back with out_ready low for cycles 3–6 → in_ready drops after 2 more accepts; outputs hold stable while stalled; all 8 tags emerge in order, with none lost or duplicated.
- Bubble collapse: one transaction, out_ready=0 for 5 cycles, then a second input → the second is accepted while the first waits at the output; release → both are delivered on consecutive cycles.
- Reset mid-flight: assert rst asynchronously between edges with 2 transactions in flight → out_valid drops immediately; after deassert, no stale result appears and in_ready=1.
